// File: rtl/rx_frame_parser.sv
// -----------------------------------------------------------------------------
// rx_frame_parser
//   Assembles framed command packets from a UART byte stream.
//   Frame layout: HEADER, CMD, LEN (0..8), LEN payload bytes, CSUM where
//   CSUM = (CMD + LEN + sum of payload) mod 256.
//   A good frame is held (frame_valid=1, receiver paused) until the consumer
//   acknowledges it. Length, checksum and inter-byte timeout violations raise
//   a one-cycle frame_err pulse with a cause held on err_code.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   rx_done      one-cycle strobe, rx_data valid in the same cycle
//   rx_data      received byte
//   rx_en_sig    receiver enable, low only while a frame is held
//   frame_valid  a good frame is held
//   frame_ack    consumer releases the held frame
//   frame_cmd    command byte of the held frame
//   frame_len    payload length of the held frame
//   pl_addr      payload read address
//   pl_data      registered payload read data (0 beyond frame_len)
//   frame_err    one-cycle error pulse
//   err_code     last error cause: 1=checksum, 2=length, 3=timeout
// -----------------------------------------------------------------------------
module rx_frame_parser #(
  parameter logic [7:0]  HEADER  = 8'hAA,
  parameter logic [15:0] TIMEOUT = 16'd50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_done,
  input  logic [7:0] rx_data,
  output logic       rx_en_sig,
  output logic       frame_valid,
  input  logic       frame_ack,
  output logic [7:0] frame_cmd,
  output logic [3:0] frame_len,
  input  logic [2:0] pl_addr,
  output logic [7:0] pl_data,
  output logic       frame_err,
  output logic [1:0] err_code
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CMD     = 3'd1,
    S_LEN     = 3'd2,
    S_PAYLOAD = 3'd3,
    S_CSUM    = 3'd4,
    S_HOLD    = 3'd5
  } state_t;

  state_t      state_q;
  logic [15:0] cnt_q;
  logic [7:0]  sum_q;
  logic [7:0]  cmd_q;
  logic [3:0]  len_q;
  logic [2:0]  idx_q;
  logic [7:0]  pl_buf_q [8];
  logic        rx_en_q;
  logic        frame_valid_q;
  logic [7:0]  frame_cmd_q;
  logic [3:0]  frame_len_q;
  logic [7:0]  pl_data_q;
  logic        frame_err_q;
  logic [1:0]  err_code_q;

  logic        collecting_s;
  logic        timeout_s;
  logic        last_byte_s;

  // Running checksum accumulation, 8-bit wrap-around.
  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

  // The inter-byte timer only matters while a frame is being collected.
  assign collecting_s = (state_q == S_CMD) || (state_q == S_LEN) ||
                        (state_q == S_PAYLOAD) || (state_q == S_CSUM);
  assign timeout_s    = collecting_s && (cnt_q == (TIMEOUT - 16'd1));
  // len_q >= 1 whenever PAYLOAD is active, so the subtraction cannot wrap there.
  assign last_byte_s  = ({1'b0, idx_q} == (len_q - 4'd1));

  // Frame FSM, inter-byte timer, payload buffer and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= 16'd0;
      sum_q         <= 8'h00;
      cmd_q         <= 8'h00;
      len_q         <= 4'd0;
      idx_q         <= 3'd0;
      for (int i = 0; i < 8; i++) begin
        pl_buf_q[i] <= 8'h00;
      end
      rx_en_q       <= 1'b1;
      frame_valid_q <= 1'b0;
      frame_cmd_q   <= 8'h00;
      frame_len_q   <= 4'd0;
      pl_data_q     <= 8'h00;
      frame_err_q   <= 1'b0;
      err_code_q    <= 2'd0;
    end else begin
      frame_err_q <= 1'b0;
      // Timeout wins over a byte arriving in the same cycle; that byte is dropped.
      if (timeout_s) begin
        frame_err_q <= 1'b1;
        err_code_q  <= 2'd3;
        state_q     <= S_IDLE;
        cnt_q       <= 16'd0;
      end else begin
        case (state_q)
          S_IDLE: begin
            cnt_q <= 16'd0;
            if (rx_done && (rx_data == HEADER)) begin
              state_q <= S_CMD;
            end
          end
          S_CMD: begin
            if (rx_done) begin
              cmd_q   <= rx_data;
              sum_q   <= rx_data;
              cnt_q   <= 16'd0;
              state_q <= S_LEN;
            end else begin
              cnt_q <= cnt_q + 16'd1;
            end
          end
          S_LEN: begin
            if (rx_done) begin
              cnt_q <= 16'd0;
              if (rx_data > 8'd8) begin
                frame_err_q <= 1'b1;
                err_code_q  <= 2'd2;
                state_q     <= S_IDLE;
              end else begin
                len_q   <= rx_data[3:0];
                sum_q   <= csum_add(sum_q, rx_data);
                idx_q   <= 3'd0;
                state_q <= (rx_data == 8'd0) ? S_CSUM : S_PAYLOAD;
              end
            end else begin
              cnt_q <= cnt_q + 16'd1;
            end
          end
          S_PAYLOAD: begin
            if (rx_done) begin
              pl_buf_q[idx_q] <= rx_data;
              sum_q           <= csum_add(sum_q, rx_data);
              cnt_q           <= 16'd0;
              if (last_byte_s) begin
                state_q <= S_CSUM;
              end else begin
                idx_q <= idx_q + 3'd1;
              end
            end else begin
              cnt_q <= cnt_q + 16'd1;
            end
          end
          S_CSUM: begin
            if (rx_done) begin
              cnt_q <= 16'd0;
              if (rx_data == sum_q) begin
                frame_cmd_q   <= cmd_q;
                frame_len_q   <= len_q;
                frame_valid_q <= 1'b1;
                rx_en_q       <= 1'b0;
                state_q       <= S_HOLD;
              end else begin
                frame_err_q <= 1'b1;
                err_code_q  <= 2'd1;
                state_q     <= S_IDLE;
              end
            end else begin
              cnt_q <= cnt_q + 16'd1;
            end
          end
          S_HOLD: begin
            // Incoming bytes are ignored; only the consumer's ack leaves HOLD.
            cnt_q <= 16'd0;
            if (frame_ack) begin
              frame_valid_q <= 1'b0;
              rx_en_q       <= 1'b1;
              state_q       <= S_IDLE;
            end
          end
          default: begin
            state_q       <= S_IDLE;
            cnt_q         <= 16'd0;
            frame_valid_q <= 1'b0;
            rx_en_q       <= 1'b1;
          end
        endcase
      end
      // Reads beyond the held length return zero, hiding stale buffer bytes.
      pl_data_q <= ({1'b0, pl_addr} < frame_len_q) ? pl_buf_q[pl_addr] : 8'h00;
    end
  end

  assign rx_en_sig   = rx_en_q;
  assign frame_valid = frame_valid_q;
  assign frame_cmd   = frame_cmd_q;
  assign frame_len   = frame_len_q;
  assign pl_data     = pl_data_q;
  assign frame_err   = frame_err_q;
  assign err_code    = err_code_q;

endmodule
